// File: rtl/drisc_bus_pkg.sv
// Shared types and helpers for the DRISC external bus interface and the
// future cache that will reuse the byte-enable decoder.
package drisc_bus_pkg;

    // Transfer size as driven by the core on data_size (3 is reserved).
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } data_size_e;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Values reported on fault_cause.
    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd2;

    // Lane enables for an access of the given size starting at byte offset.
    // Lanes shifted past bit 3 fall off; such accesses are misaligned anyway.
    function automatic logic [3:0] byte_enable_for(input logic [1:0] offset,
                                                   input logic [1:0] size);
        logic [3:0] lanes;
        case (size)
            SIZE_BYTE: lanes = 4'b0001 << offset;
            SIZE_HALF: lanes = 4'b0011 << offset;
            SIZE_WORD: lanes = 4'b1111;
            default:   lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    // An access must sit on its natural boundary; the reserved size never fits.
    function automatic logic access_misaligned(input logic [1:0] offset,
                                               input logic [1:0] size);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'd0);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/drisc_bus_interface_decoder.sv
// Combinational (offset, size) -> (byte_enable, misaligned) decoder.
// Misaligned accesses report no lanes so nothing downstream can act on them.
module drisc_byte_enable_decoder
    import drisc_bus_pkg::*;
(
    input  logic [1:0] offset,
    input  logic [1:0] size,
    output logic [3:0] byte_enable,
    output logic       misaligned
);

    logic [3:0] lane_enable;

    assign lane_enable = byte_enable_for(offset, size);
    assign misaligned  = access_misaligned(offset, size);

    // Each lane is only enabled for a legal access.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_enable[gi] = lane_enable[gi] & ~misaligned;
        end
    endgenerate

endmodule

// File: rtl/drisc_bus_interface.sv
// DRISC external bus interface: turns the core's strobe bus into a single
// outstanding valid/ready memory request, holds the core until the access
// retires, returns registered read data and records misalignment/timeouts.
module drisc_bus_interface
    import drisc_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_address_bus,
    input  logic        cpu_write_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_out,
    input  logic        cpu_data_out_enable,
    output logic [31:0] cpu_data_in,
    output logic        hold,
    output logic [29:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_request,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    input  logic        fault_clear
);

    // The abort fires at the end of the REQ cycle in which the counter would
    // reach TIMEOUT_CYCLES, i.e. while it still reads TIMEOUT_CYCLES-1.
    localparam bit TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                   state_reg,      state_next;
    logic [31:0]              addr_latch_reg, addr_latch_next;
    logic [29:0]              req_addr_reg,   req_addr_next;
    logic [3:0]               be_reg,         be_next;
    logic [31:0]              wdata_reg,      wdata_next;
    logic                     write_reg,      write_next;
    logic                     request_reg,    request_next;
    logic                     hold_reg,       hold_next;
    logic [31:0]              rdata_reg,      rdata_next;
    logic                     fault_reg,      fault_next;
    logic [1:0]               cause_reg,      cause_next;
    logic [TIMEOUT_WIDTH-1:0] count_reg,      count_next;
    // Set once a strobe has been consumed; cleared when both strobes are low.
    logic                     rearm_reg,      rearm_next;

    logic [3:0] dec_byte_enable;
    logic       dec_misaligned;
    logic       strobe;
    logic       timeout_hit;
    logic       new_fault;
    logic [1:0] new_cause;

    drisc_byte_enable_decoder u_be_decoder (
        .offset      (addr_latch_reg[1:0]),
        .size        (cpu_data_size),
        .byte_enable (dec_byte_enable),
        .misaligned  (dec_misaligned)
    );

    assign strobe      = cpu_read | cpu_write;
    assign timeout_hit = TIMEOUT_ENABLED && (count_reg == TIMEOUT_LAST);

    // While an access is in flight the address is frozen at the value it was
    // issued with, so a late address strobe cannot disturb the request.
    assign mem_address     = (state_reg == IDLE) ? addr_latch_reg[31:2] : req_addr_reg;
    assign mem_byte_enable = be_reg;
    assign mem_write_data  = wdata_reg;
    assign mem_write       = write_reg;
    assign mem_request     = request_reg;
    assign hold            = hold_reg;
    assign cpu_data_in     = rdata_reg;
    assign fault           = fault_reg;
    assign fault_cause     = cause_reg;

    // State and datapath registers; reset withdraws any request immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            addr_latch_reg <= '0;
            req_addr_reg   <= '0;
            be_reg         <= '0;
            wdata_reg      <= '0;
            write_reg      <= 1'b0;
            request_reg    <= 1'b0;
            hold_reg       <= 1'b0;
            rdata_reg      <= '0;
            fault_reg      <= 1'b0;
            cause_reg      <= CAUSE_NONE;
            count_reg      <= '0;
            rearm_reg      <= 1'b1;
        end else begin
            state_reg      <= state_next;
            addr_latch_reg <= addr_latch_next;
            req_addr_reg   <= req_addr_next;
            be_reg         <= be_next;
            wdata_reg      <= wdata_next;
            write_reg      <= write_next;
            request_reg    <= request_next;
            hold_reg       <= hold_next;
            rdata_reg      <= rdata_next;
            fault_reg      <= fault_next;
            cause_reg      <= cause_next;
            count_reg      <= count_next;
            rearm_reg      <= rearm_next;
        end
    end

    // Next-state logic: accept, wait for memory or time out, then release.
    always_comb begin
        state_next      = state_reg;
        addr_latch_next = addr_latch_reg;
        req_addr_next   = req_addr_reg;
        be_next         = be_reg;
        wdata_next      = wdata_reg;
        write_next      = write_reg;
        request_next    = request_reg;
        hold_next       = hold_reg;
        rdata_next      = rdata_reg;
        count_next      = count_reg;
        rearm_next      = rearm_reg;
        fault_next      = fault_reg;
        cause_next      = cause_reg;
        new_fault       = 1'b0;
        new_cause       = CAUSE_NONE;

        if (cpu_write_address) begin
            addr_latch_next = cpu_address_bus;
        end

        if (!strobe) begin
            rearm_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (strobe && !rearm_reg) begin
                    rearm_next = 1'b1;
                    if (dec_misaligned) begin
                        new_fault = 1'b1;
                        new_cause = CAUSE_MISALIGNED;
                    end else begin
                        // A simultaneous read and write resolves to a write.
                        state_next    = REQ;
                        request_next  = 1'b1;
                        hold_next     = 1'b1;
                        write_next    = cpu_write;
                        wdata_next    = cpu_data_out_enable ? cpu_data_out : 32'h0;
                        be_next       = dec_byte_enable;
                        req_addr_next = addr_latch_reg[31:2];
                        count_next    = '0;
                    end
                end
            end

            REQ: begin
                if (mem_ready) begin
                    if (!write_reg) begin
                        rdata_next = mem_read_data;
                    end
                    state_next   = DONE;
                    request_next = 1'b0;
                    write_next   = 1'b0;
                    be_next      = '0;
                end else if (timeout_hit) begin
                    // Reads that never complete return all-ones to the core.
                    if (!write_reg) begin
                        rdata_next = 32'hFFFF_FFFF;
                    end
                    new_fault    = 1'b1;
                    new_cause    = CAUSE_TIMEOUT;
                    state_next   = DONE;
                    request_next = 1'b0;
                    write_next   = 1'b0;
                    be_next      = '0;
                end else begin
                    count_next = count_reg + TIMEOUT_WIDTH'(1);
                end
            end

            DONE: begin
                hold_next  = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next   = IDLE;
                request_next = 1'b0;
                hold_next    = 1'b0;
            end
        endcase

        // Sticky fault: first cause is kept, but a fault arriving together
        // with fault_clear replaces the old one.
        if (fault_clear) begin
            fault_next = 1'b0;
            cause_next = CAUSE_NONE;
        end
        if (new_fault) begin
            fault_next = 1'b1;
            if (!fault_reg || fault_clear) begin
                cause_next = new_cause;
            end
        end
    end

endmodule
